// File: rtl/relay_pkg.sv
// Shared definitions for the relay sender: observable state encoding and grace limits.
package relay_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StThrottle = 2'd2,
    StBlocked  = 2'd3
  } relay_state_e;

  localparam int unsigned RELAY_MIN_GRACE = 2;

endpackage

// File: rtl/relay_grace_counter.sv
// Registers the downstream full_n flag and counts issues made while it is low,
// granting at most GRACE_PERIOD-2 new issues per low interval.
module relay_grace_counter
  import relay_pkg::*;
#(
  parameter int unsigned GRACE_PERIOD = 4,
  parameter int unsigned CNT_WIDTH    = $clog2(GRACE_PERIOD + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic dst_full_n,
  input  logic src_read,
  output logic full_n_q,
  output logic can_send
);

  if (GRACE_PERIOD < RELAY_MIN_GRACE) begin : g_bad_grace
    $error("relay_grace_counter: GRACE_PERIOD must be >= 2");
  end

  // Two writes are already in the register loop when the low flag is seen.
  localparam logic [CNT_WIDTH-1:0] GcntMax = CNT_WIDTH'(GRACE_PERIOD - RELAY_MIN_GRACE);

  logic [CNT_WIDTH-1:0] gcnt_q, gcnt_d;

  always_comb begin
    gcnt_d = gcnt_q;
    if (full_n_q) begin
      gcnt_d = '0;
    end else if (src_read && (gcnt_q < GcntMax)) begin
      gcnt_d = gcnt_q + CNT_WIDTH'(1);
    end
  end

  assign can_send = full_n_q | (gcnt_q < GcntMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_n_q <= 1'b1;
      gcnt_q   <= '0;
    end else begin
      full_n_q <= dst_full_n;
      gcnt_q   <= gcnt_d;
    end
  end

endmodule

// File: rtl/relay_sender.sv
// Drains an FWFT FIFO into a relay-station write port through a registered stage.
// Optional RELAY_SENDER_STATS_EN adds write-count and blocked-cycle counters.
module relay_sender
  import relay_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GRACE_PERIOD = 4,
  localparam int unsigned CNT_WIDTH   = $clog2(GRACE_PERIOD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  src_empty_n,
  output logic                  src_read,
  input  logic [DATA_WIDTH-1:0] src_dout,
  input  logic                  dst_full_n,
  output logic                  dst_write,
  output logic [DATA_WIDTH-1:0] dst_din
`ifdef RELAY_SENDER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [31:0]           stat_stall
`endif
);

  logic         full_n_q;
  logic         can_send;
  relay_state_e state_q, state_d;

  assign src_read = enable & src_empty_n & can_send & ~reset;

  relay_grace_counter #(
    .GRACE_PERIOD (GRACE_PERIOD),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_grace (
    .clk        (clk),
    .reset      (reset),
    .dst_full_n (dst_full_n),
    .src_read   (src_read),
    .full_n_q   (full_n_q),
    .can_send   (can_send)
  );

  always_comb begin
    state_d = StIdle;
    if (src_read) begin
      state_d = full_n_q ? StRun : StThrottle;
    end else if (enable && src_empty_n && !can_send) begin
      state_d = StBlocked;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_write <= 1'b0;
      dst_din   <= '0;
      state_q   <= StIdle;
    end else begin
      dst_write <= src_read;
      if (src_read) begin
        dst_din <= src_dout;
      end
      state_q <= state_d;
    end
  end

`ifdef RELAY_SENDER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (dst_write) begin
        stat_words <= stat_words + 32'd1;
      end
      if (state_q == StBlocked) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_relay_sender.sv
// Randomized and directed bench for relay_sender against a queue-based reference model.
module tb_relay_sender;

  localparam int G = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, src_empty_n, dst_full_n;
  logic        src_read, dst_write;
  logic [31:0] src_dout, dst_din;
  logic        src_read2, dst_write2, dst_full_n2;
  logic [31:0] dst_din2;
`ifdef RELAY_SENDER_STATS_EN
  logic [31:0] stat_words, stat_stall, stat_words2, stat_stall2;
`endif

  always #5 clk = ~clk;

  relay_sender #(.DATA_WIDTH(32), .GRACE_PERIOD(G)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .src_empty_n (src_empty_n),
    .src_read    (src_read),
    .src_dout    (src_dout),
    .dst_full_n  (dst_full_n),
    .dst_write   (dst_write),
    .dst_din     (dst_din)
`ifdef RELAY_SENDER_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stall  (stat_stall)
`endif
  );

  relay_sender #(.DATA_WIDTH(32), .GRACE_PERIOD(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .enable      (1'b1),
    .src_empty_n (1'b1),
    .src_read    (src_read2),
    .src_dout    (32'hA5A5_0000),
    .dst_full_n  (dst_full_n2),
    .dst_write   (dst_write2),
    .dst_din     (dst_din2)
`ifdef RELAY_SENDER_STATS_EN
    ,
    .stat_words  (stat_words2),
    .stat_stall  (stat_stall2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] srcq[$];
  bit          fq;
  int          used;
  bit          exp_w;
  logic [31:0] exp_d;
  int          exp_st;
  int          low_writes;
  logic [31:0] sw, ss;
  bit          full2_nx = 1'b1;
  bit          w2_s, r2_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq = 1'b1; used = 0; exp_w = 1'b0; exp_d = '0; exp_st = 0;
    low_writes = 0; sw = '0; ss = '0;
  endtask

  // One clock cycle: drive after negedge, check, then advance the model past the posedge.
  task automatic cycle_run(input bit en_v, input bit full_v);
    bit exp_rd;
    @(negedge clk);
    enable      = en_v;
    dst_full_n  = full_v;
    dst_full_n2 = full2_nx;
    src_empty_n = (srcq.size() != 0);
    src_dout    = src_empty_n ? srcq[0] : $urandom;
    #1;
    exp_rd = en_v && src_empty_n && (fq || (used < G - 2));
    chk("src_read", src_read, exp_rd);
    chk("dst_write", dst_write, exp_w);
    chk("dst_din", dst_din, exp_d);
    chk("state", dut.state_q, exp_st);
`ifdef RELAY_SENDER_STATS_EN
    chk("stat_words", stat_words, sw);
    chk("stat_stall", stat_stall, ss);
`endif
    if (!full_v) begin
      if (dst_write) low_writes++;
      if (low_writes > G) chk("grace_budget", low_writes, G);
    end else begin
      low_writes = 0;
    end
    w2_s = dst_write2;
    r2_s = src_read2;
    sw += 32'(exp_w);
    ss += 32'(exp_st == 3);
    if (exp_rd) exp_d = srcq.pop_front();
    exp_w  = exp_rd;
    exp_st = exp_rd ? (fq ? 1 : 2) : ((en_v && src_empty_n) ? 3 : 0);
    if (fq) used = 0;
    else if (exp_rd) used++;
    fq = full_v;
  endtask

  initial begin
    int k, first_r, first_w, last_w, bp, w2, r2;
    bit full_r, seen;
    logic [31:0] first_d;

    reset = 1'b1; enable = 1'b0; src_empty_n = 1'b0; dst_full_n = 1'b1;
    dst_full_n2 = 1'b1; src_dout = '0;
    model_reset();
    #12;
    chk("rst_dst_write", dst_write, 0);
    chk("rst_dst_din", dst_din, 0);
    chk("rst_src_read", src_read, 0);
    chk("rst_state", dut.state_q, 0);
    @(negedge clk);
    reset = 1'b0;

    // Free flow: words 0..15 stream out back to back with one cycle of latency.
    for (int i = 0; i < 16; i++) srcq.push_back(32'(i));
    k = 0; first_r = -1; first_w = -1; last_w = -1;
    for (int c = 0; c < 20; c++) begin
      cycle_run(1'b1, 1'b1);
      if (src_read && first_r < 0) first_r = c;
      if (dst_write) begin
        chk("ff_data", dst_din, k);
        k++;
        if (first_w < 0) first_w = c;
        last_w = c;
      end
    end
    chk("ff_count", k, 16);
    chk("ff_latency", first_w - first_r, 1);
    chk("ff_consecutive", last_w - first_w, 15);

    // Backpressure from cycle 10, release at cycle 30.
    for (int i = 0; i < 40; i++) srcq.push_back(32'(100 + i));
    bp = 0;
    for (int c = 0; c < 40; c++) begin
      cycle_run(1'b1, !(c >= 10 && c < 30));
      if (c >= 10 && c < 30 && dst_write) bp++;
      if (c == 20) begin
        chk("bp_read_stalled", src_read, 0);
        chk("bp_state_blocked", dut.state_q, 3);
      end
      if (c == 30) chk("rel_read_c30", src_read, 0);
      if (c == 31) begin
        chk("rel_read_c31", src_read, 1);
        chk("rel_write_c31", dst_write, 0);
      end
      if (c == 32) chk("rel_write_c32", dst_write, 1);
    end
    chk("bp_writes", bp, 4);

    // Randomized traffic with bursty backpressure and enable gaps.
    full_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (srcq.size() < 16 && $urandom_range(0, 1) == 1) srcq.push_back($urandom);
      if ($urandom_range(0, 7) == 0) full_r = ~full_r;
      cycle_run($urandom_range(0, 7) != 0, full_r);
    end

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 10; i++) srcq.push_back(32'(300 + i));
    for (int c = 0; c < 4; c++) cycle_run(1'b1, 1'b1);
    chk("pre_rst_write", dst_write, 1);
    #2;
    reset = 1'b1; enable = 1'b0; src_empty_n = 1'b0;
    #1;
    chk("async_rst_write", dst_write, 0);
    chk("async_rst_read", src_read, 0);
    chk("async_rst_din", dst_din, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    srcq.delete();
    for (int i = 0; i < 4; i++) srcq.push_back(32'(500 + i));
    seen = 1'b0; first_d = '0;
    for (int c = 0; c < 6; c++) begin
      cycle_run(1'b1, 1'b1);
      if (dst_write && !seen) begin
        seen = 1'b1;
        first_d = dst_din;
      end
    end
    chk("rst_restart_seen", seen, 1);
    chk("rst_restart_data", first_d, 500);

    // GRACE_PERIOD=2 instance: no new issues once its full_n goes low.
    w2 = 0; r2 = 0;
    for (int c = 0; c < 16; c++) begin
      full2_nx = (c < 5);
      cycle_run(1'b0, 1'b1);
      if (c == 4) chk("g2_read_before_low", r2_s, 1);
      if (c >= 5 && w2_s) w2++;
      if (c >= 6 && r2_s) r2++;
    end
    chk("g2_writes_low", w2, 2);
    chk("g2_reads_low", r2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
